// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the two-port memory arbiter.
//   state_e : arbiter FSM states
//   port_e  : requester identifier (instruction fetch / data)
package mem_arb_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      RESP   = 2'd3
   } state_e;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_e;

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner selection between the I and D requesters.
//   i_req  : instruction-fetch request pending
//   d_req  : data request pending
//   last   : port granted most recently
//   winner : port to grant (only meaningful when a request is pending)
// Build option: MEM_ARB_RR_EN -- ties alternate against `last`; otherwise D
// always wins a tie and `last` is ignored.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic  i_req,
   input  logic  d_req,
   input  port_e last,
   output port_e winner
);

`ifndef MEM_ARB_RR_EN
   logic unused_last;
   assign unused_last = last;
`endif

   always_comb begin
      winner = PORT_I;
      if (d_req && !i_req) begin
         winner = PORT_D;
      end else if (d_req && i_req) begin
`ifdef MEM_ARB_RR_EN
         winner = (last == PORT_D) ? PORT_I : PORT_D;
`else
         winner = PORT_D;
`endif
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// port (read only) and a data port (read/write).
//   clk_i, rst_i                    : clock, async active-high reset
//   i_req_i/i_addr_i                : fetch request (level) and address
//   i_ack_o/i_rdata_o/i_stall_o     : fetch completion pulse, data, stall
//   d_req_i/d_we_i/d_addr_i/d_wdata_i : data-port request bundle
//   d_ack_o/d_rdata_o/d_stall_o     : data completion pulse, data, stall
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o : memory request bundle
//   mem_ack_i/mem_rdata_i           : memory completion pulse and read data
// Build option: MEM_ARB_RR_EN selects round-robin tie breaking (see arb_pick).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              i_req_i,
   input  logic [ADDR_W-1:0] i_addr_i,
   output logic              i_ack_o,
   output logic [DATA_W-1:0] i_rdata_o,
   output logic              i_stall_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_ack_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_stall_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   state_e state, state_nxt;
   port_e  last_gnt, winner;
   logic   any_req;

   assign any_req = i_req_i | d_req_i;

   arb_pick u_pick (
      .i_req  (i_req_i),
      .d_req  (d_req_i),
      .last   (last_gnt),
      .winner (winner)
   );

   // Stall releases in the ack cycle so the requester advances exactly once.
   assign i_stall_o = i_req_i & ~i_ack_o;
   assign d_stall_o = d_req_i & ~d_ack_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:           if (any_req) state_nxt = (winner == PORT_D) ? BUSY_D : BUSY_I;
         BUSY_I, BUSY_D: if (mem_ack_i) state_nxt = RESP;
         RESP:           state_nxt = IDLE;
         default:        state_nxt = IDLE;
      endcase
   end

   // Request bundle, read-data capture and ack pulses. mem_ack_i only has
   // an effect in the BUSY states, so stray or post-reset acks are dropped.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         i_rdata_o   <= '0;
         d_rdata_o   <= '0;
         i_ack_o     <= 1'b0;
         d_ack_o     <= 1'b0;
         last_gnt    <= PORT_I;
      end else begin
         i_ack_o <= 1'b0;
         d_ack_o <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  mem_req_o <= 1'b1;
                  last_gnt  <= winner;
                  if (winner == PORT_D) begin
                     mem_we_o    <= d_we_i;
                     mem_addr_o  <= d_addr_i;
                     mem_wdata_o <= d_wdata_i;
                  end else begin
                     mem_we_o    <= 1'b0;
                     mem_addr_o  <= i_addr_i;
                     mem_wdata_o <= '0;
                  end
               end
            end
            BUSY_I: begin
               if (mem_ack_i) begin
                  mem_req_o <= 1'b0;
                  i_rdata_o <= mem_rdata_i;
                  i_ack_o   <= 1'b1;
               end
            end
            BUSY_D: begin
               if (mem_ack_i) begin
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  if (!mem_we_o) d_rdata_o <= mem_rdata_i;
                  d_ack_o   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter plus hand
// sequences for reset mid-transaction and sustained contention.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
   logic        i_ack_o, i_stall_o, d_ack_o, d_stall_o, mem_req_o, mem_we_o;
   logic [31:0] i_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i(clk), .rst_i(rst),
      .i_req_i(i_req), .i_addr_i(i_addr),
      .i_ack_o(i_ack_o), .i_rdata_o(i_rdata_o), .i_stall_o(i_stall_o),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o), .d_stall_o(d_stall_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
   );

   // flags = {mem_req, mem_we, i_ack, d_ack, i_stall, d_stall}
   typedef struct {
      logic        i_req;
      logic [31:0] i_addr;
      logic        d_req, d_we;
      logic [31:0] d_addr, d_wdata;
      logic        mem_ack;
      logic [31:0] mem_rdata;
      logic [5:0]  e_flags;
      logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dd, input logic ma,
                      input logic [31:0] md, input logic [5:0] fl, input logic [31:0] ea,
                      input logic [31:0] ew, input logic [31:0] eir, input logic [31:0] edr);
      vec_t v;
      v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
      v.mem_ack = ma; v.mem_rdata = md; v.e_flags = fl; v.e_addr = ea; v.e_wdata = ew;
      v.e_irdata = eir; v.e_drdata = edr;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic quiet_inputs();
      i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      mem_ack = 0; mem_rdata = 0;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      quiet_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   port_e got[$];
   int    cyc;

   initial begin
      // I read 0x10, ack one cycle after mem_req
      add(1,32'h10,0,0,0,0,0,0,                6'b000010,32'h10*0,0,0,0);
      add(1,32'h10,0,0,0,0,0,0,                6'b100010,32'h10,0,0,0);
      add(1,32'h10,0,0,0,0,1,32'h2002_0005,    6'b100010,32'h10,0,0,0);
      add(1,32'h10,0,0,0,0,0,0,                6'b001000,32'h10,0,32'h2002_0005,0);
      add(0,0,0,0,0,0,0,0,                     6'b000000,32'h10,0,32'h2002_0005,0);
      // tie: I read 0x04 vs D write 0x100, zero-wait memory -> D first
      add(1,32'h4,1,1,32'h100,32'hDEAD_BEEF,0,0,            6'b000011,32'h10,0,32'h2002_0005,0);
      add(1,32'h4,1,1,32'h100,32'hDEAD_BEEF,1,32'h1111_1111,6'b110011,32'h100,32'hDEAD_BEEF,32'h2002_0005,0);
      add(1,32'h4,1,1,32'h100,32'hDEAD_BEEF,0,0,            6'b000110,32'h100,32'hDEAD_BEEF,32'h2002_0005,0);
      add(1,32'h4,0,0,0,0,0,0,                 6'b000010,32'h100,32'hDEAD_BEEF,32'h2002_0005,0);
      add(1,32'h4,0,0,0,0,1,32'h3030_3030,     6'b100010,32'h4,0,32'h2002_0005,0);
      add(1,32'h4,0,0,0,0,0,0,                 6'b001000,32'h4,0,32'h3030_3030,0);
      add(0,0,0,0,0,0,0,0,                     6'b000000,32'h4,0,32'h3030_3030,0);
      // zero-wait back-to-back D reads 0x0, 0x4, then a stray ack in IDLE
      add(0,0,1,0,32'h0,0,0,0,                 6'b000001,32'h4,0,32'h3030_3030,0);
      add(0,0,1,0,32'h0,0,1,32'hA0A0_A0A0,     6'b100001,32'h0,0,32'h3030_3030,0);
      add(0,0,1,0,32'h0,0,0,0,                 6'b000100,32'h0,0,32'h3030_3030,32'hA0A0_A0A0);
      add(0,0,1,0,32'h4,0,0,0,                 6'b000001,32'h0,0,32'h3030_3030,32'hA0A0_A0A0);
      add(0,0,1,0,32'h4,0,1,32'hB4B4_B4B4,     6'b100001,32'h4,0,32'h3030_3030,32'hA0A0_A0A0);
      add(0,0,1,0,32'h4,0,0,0,                 6'b000100,32'h4,0,32'h3030_3030,32'hB4B4_B4B4);
      add(0,0,0,0,0,0,1,32'hFFFF_FFFF,         6'b000000,32'h4,0,32'h3030_3030,32'hB4B4_B4B4);
      add(0,0,0,0,0,0,0,0,                     6'b000000,32'h4,0,32'h3030_3030,32'hB4B4_B4B4);
      // D drops request while granted; memory acks 5 cycles after mem_req
      add(0,0,1,0,32'h20,0,0,0,                6'b000001,32'h4,0,32'h3030_3030,32'hB4B4_B4B4);
      for (int k = 0; k < 5; k++)
         add(0,0,0,0,0,0,0,0,                  6'b100000,32'h20,0,32'h3030_3030,32'hB4B4_B4B4);
      add(0,0,0,0,0,0,1,32'h55AA_55AA,         6'b100000,32'h20,0,32'h3030_3030,32'hB4B4_B4B4);
      add(0,0,0,0,0,0,0,0,                     6'b000100,32'h20,0,32'h3030_3030,32'h55AA_55AA);
      add(0,0,0,0,0,0,0,0,                     6'b000000,32'h20,0,32'h3030_3030,32'h55AA_55AA);

      // reset state
      quiet_inputs();
      @(negedge clk);
      @(negedge clk);
      chk("reset outputs",
          {mem_req_o, mem_we_o, i_ack_o, d_ack_o, i_stall_o, d_stall_o,
           mem_addr_o, mem_wdata_o, i_rdata_o, d_rdata_o}, '0);
      rst = 1'b0;

      foreach (vq[n]) begin
         @(negedge clk);
         i_req = vq[n].i_req; i_addr = vq[n].i_addr;
         d_req = vq[n].d_req; d_we = vq[n].d_we; d_addr = vq[n].d_addr; d_wdata = vq[n].d_wdata;
         mem_ack = vq[n].mem_ack; mem_rdata = vq[n].mem_rdata;
         #1;
         chk($sformatf("vec %0d", n),
             {mem_req_o, mem_we_o, i_ack_o, d_ack_o, i_stall_o, d_stall_o,
              mem_addr_o, mem_wdata_o, i_rdata_o, d_rdata_o},
             {vq[n].e_flags, vq[n].e_addr, vq[n].e_wdata, vq[n].e_irdata, vq[n].e_drdata});
      end

      // reset in BUSY_D, late ack after release must be dropped
      @(negedge clk);
      quiet_inputs();
      d_req = 1; d_addr = 32'h40;
      @(negedge clk);
      chk("rst_mid busy", {mem_req_o, mem_addr_o}, {1'b1, 32'h40});
      rst = 1'b1; d_req = 0;
      #1;
      chk("rst_mid async clear", {mem_req_o, d_ack_o, mem_addr_o, d_rdata_o, i_rdata_o}, '0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      mem_ack = 1; mem_rdata = 32'h99;
      #1;
      chk("late ack cycle", {mem_req_o, d_ack_o}, '0);
      @(negedge clk);
      mem_ack = 0;
      #1;
      chk("late ack ignored", {mem_req_o, d_ack_o, i_ack_o, d_rdata_o}, '0);
      d_req = 1; d_addr = 32'h8;
      @(negedge clk);
      chk("post-rst grant", {mem_req_o, mem_addr_o}, {1'b1, 32'h8});
      mem_ack = 1; mem_rdata = 32'h77;
      @(negedge clk);
      mem_ack = 0;
      #1;
      chk("post-rst dack", {d_ack_o, d_rdata_o}, {1'b1, 32'h77});

      // sustained contention with zero-wait memory, fresh from reset
      reset_pulse();
      i_req = 1; i_addr = 32'h4;
      d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
      cyc = 0;
      while (got.size() < 6 && cyc < 200) begin
         @(negedge clk);
         mem_ack = mem_req_o;
         if (mem_req_o) got.push_back(mem_we_o ? PORT_D : PORT_I);
         cyc++;
      end
      quiet_inputs();
      if (got.size() < 6) chk("contention grants seen", got.size(), 6);
      foreach (got[k]) begin
`ifdef MEM_ARB_RR_EN
         chk($sformatf("rr grant %0d", k), got[k], (k % 2 == 0) ? PORT_D : PORT_I);
`else
         chk($sformatf("fixed grant %0d", k), got[k], PORT_D);
`endif
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock, clk_i; reset rst_i SHALL be asynchronous and active-high.
REQ-002 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width.
REQ-003 clk_i  input  1  clock, all state on rising edge.
REQ-004 rst_i  input  1  asynchronous active-high reset.
REQ-005 i_req_i / i_addr_i  input  1 / ADDR_W  instruction-fetch read request (level) and address.
REQ-006 i_ack_o / i_rdata_o / i_stall_o  output  1 / DATA_W / 1  fetch completion pulse, read data, stall to PC and IF_ID.
REQ-007 d_req_i / d_we_i / d_addr_i / d_wdata_i  input  1 / 1 / ADDR_W / DATA_W  data-port request, write enable, address, write data.
REQ-008 d_ack_o / d_rdata_o / d_stall_o  output  1 / DATA_W / 1  data completion pulse, read data, pipeline-wide stall.
REQ-009 mem_req_o / mem_we_o / mem_addr_o / mem_wdata_o  output  1 / 1 / ADDR_W / DATA_W  single-port memory request bundle.
REQ-010 mem_ack_i / mem_rdata_i  input  1 / DATA_W  memory completion pulse and read data.

Function
REQ-011 The FSM SHALL have states IDLE, BUSY_I, BUSY_D, RESP.
REQ-012 In IDLE with any request pending, the block SHALL grant one port and enter BUSY_I or BUSY_D on the next edge; with no request it SHALL stay in IDLE.
REQ-013 On the cycle i_req_i and d_req_i are both high in IDLE, the D port SHALL win (fixed priority, default build).
REQ-014 On grant, mem_req_o and the granted address/we/wdata SHALL be registered and held stable until mem_ack_i is sampled high.
REQ-015 mem_ack_i SHALL be honoured only in BUSY_I/BUSY_D; it is legal in the first BUSY cycle; mem_ack_i outside BUSY SHALL be ignored.
REQ-016 On mem_ack_i in BUSY_x, the block SHALL deassert mem_req_o, capture mem_rdata_i into x_rdata_o, and enter RESP.
REQ-017 In RESP, x_ack_o SHALL be high for exactly that one cycle for the granted port; next state SHALL be IDLE.
REQ-018 x_rdata_o SHALL hold its value until the next completion on that port; for writes d_rdata_o SHALL be unchanged.
REQ-019 Minimum latency SHALL be 2 cycles: req sampled at cycle 0, mem_req_o at 1, mem_ack_i at 1, ack_o at 2.
REQ-020 x_stall_o SHALL equal x_req_i AND NOT x_ack_o (combinational).
REQ-021 If the requester drops x_req_i while granted, the memory transaction SHALL complete and x_ack_o SHALL still pulse.
REQ-022 mem_we_o SHALL be 0 for every I-port grant.

Reset
REQ-023 Reset SHALL force state IDLE; mem_req_o, mem_we_o, i_ack_o, d_ack_o = 0; mem_addr_o, mem_wdata_o, i_rdata_o, d_rdata_o = 0; last-grant register = I.
REQ-024 Reset asserted mid-transaction SHALL abandon it with no ack pulse; a late mem_ack_i after reset SHALL be ignored.

Configuration
REQ-025 With MEM_ARB_RR_EN defined, simultaneous requests SHALL be granted to the port not granted last (round-robin; after reset D wins first tie); without it, REQ-013 fixed D priority SHALL apply and the last-grant register SHALL be unused.

Structure
REQ-026 Package mem_arb_pkg SHALL hold the FSM state enum, the port-select enum (PORT_I, PORT_D) and default widths.
REQ-027 Grant selection SHALL be a sub-module arb_pick (inputs: two requests, last grant; output: winner); FSM and registers stay in mem_arbiter.

Verification
REQ-028 I-only read, addr 0x0000_0010, memory acks 1 cycle after mem_req_o, rdata 0x2002_0005 -> i_ack_o pulses cycle 3, i_rdata_o = 0x2002_0005, i_stall_o high cycles 0-2.
REQ-029 Simultaneous I read 0x04 and D write 0x100 data 0xDEAD_BEEF, default build -> D served first with mem_we_o = 1; I served next; d_ack_o precedes i_ack_o.
REQ-030 Same tie repeated three times with MEM_ARB_RR_EN -> grant order D, I, D, I, D, I.
REQ-031 Zero-wait memory (mem_ack_i same cycle as mem_req_o), back-to-back D reads 0x0, 0x4 -> each completes in 2 cycles, one IDLE cycle between.
REQ-032 rst_i asserted in BUSY_D with mem_ack_i arriving one cycle after release -> no d_ack_o, state IDLE, mem_req_o = 0.
REQ-033 D requester drops d_req_i while BUSY_D, memory acks 5 cycles later -> d_ack_o pulses once, d_stall_o stays 0.
